// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate interface between the VGA raster producer and its consumers
// (sprites, titles, overlays).
interface vga_timing_gen_if;
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_end;

    modport master (output p_tick, x, y, video_on, hsync, vsync, frame_end);
    modport slave  (input  p_tick, x, y, video_on, hsync, vsync, frame_end);
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: pixel-tick divider, h/v counters, active-low syncs.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [7:0]       frame_cnt,
`endif
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0]       V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0]       HS_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             p_tick_s;
    logic             h_last_s;
    logic             v_last_s;
    logic             frame_end_s;

    // Next-state for divider and counters; syncs derive from the next count so they line up with x/y.
    always_comb begin
        p_tick_s = (div_q == DIV_LAST);
        h_last_s = (h_q == H_LAST);
        v_last_s = (v_q == V_LAST);
        div_d    = div_q;
        h_d      = h_q;
        v_d      = v_q;
        if (p_tick_s) begin
            div_d = '0;
            if (h_last_s) begin
                h_d = 10'd0;
                if (v_last_s) begin
                    v_d = 10'd0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
                v_d = v_q;
            end
        end else begin
            div_d = div_q + DIV_ONE;
        end
        hsync_d     = ~((h_d >= HS_START) && (h_d <= HS_END));
        vsync_d     = ~((v_d >= VS_START) && (v_d <= VS_END));
        frame_end_s = p_tick_s & h_last_s & v_last_s;
    end

    // Raster state registers; reset drops any sync pulse in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga.p_tick    = p_tick_s;
    assign vga.x         = h_q;
    assign vga.y         = v_q;
    assign vga.video_on  = (h_q < H_DISP) && (v_q < V_DISP);
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.frame_end = frame_end_s;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Free-running frame count for blink/animation timing, wraps naturally at 256.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 8'd0;
        end else if (frame_end_s) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_q <= frame_cnt_q;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    // No frame counter in this build; frame_end alone marks frame boundaries.
`endif

endmodule
